// File: rtl/mul_eval_pkg.sv
// Shared types and arithmetic helpers for the exhaustive error-threshold evaluators.
package mul_eval_pkg;

    localparam int DEF_IN_W  = 4;
    localparam int DEF_OUT_W = 4;
    localparam int DEF_ET    = 5;

    // Helpers work at a fixed generous width; callers zero-extend operands and truncate results.
    localparam int OP_W  = 16;
    localparam int ARG_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Unsigned exact product of the two operand halves.
    function automatic logic [ARG_W-1:0] exact_mul(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        return ARG_W'(a) * ARG_W'(b);
    endfunction

    // Unsigned absolute difference.
    function automatic logic [ARG_W-1:0] abs_diff(input logic [ARG_W-1:0] x, input logic [ARG_W-1:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/approx_error_monitor_err_accum.sv
// Error metric accumulator: max, sum and threshold-violation count over one sweep.
module err_accum
    import mul_eval_pkg::*;
#(
    parameter int W     = DEF_OUT_W,
    parameter int SUM_W = 8,
    parameter int CNT_W = 5,
    parameter int ET    = DEF_ET
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             sample_valid_i,
    input  logic             finalize_i,
    input  logic [W-1:0]     exact_i,
    input  logic [W-1:0]     approx_i,
    output logic [W-1:0]     max_err_o,
    output logic [SUM_W-1:0] sum_err_o,
    output logic [CNT_W-1:0] viol_cnt_o,
    output logic             pass_o
);

    localparam logic [W-1:0] ET_W = W'(ET);

    logic [W-1:0]     err;
    logic [CNT_W-1:0] viol_next;

    // Per-sample error and the violation count including the sample of this cycle,
    // so the pass verdict can be taken on the same edge as the final sample.
    always_comb begin
        err       = W'(abs_diff(ARG_W'(exact_i), ARG_W'(approx_i)));
        viol_next = viol_cnt_o;
        if (sample_valid_i && (err > ET_W)) begin
            viol_next = viol_cnt_o + CNT_W'(1);
        end
    end

    // Metric registers; clear wins over a coincident sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_err_o  <= '0;
            sum_err_o  <= '0;
            viol_cnt_o <= '0;
            pass_o     <= 1'b0;
        end else if (clear_i) begin
            max_err_o  <= '0;
            sum_err_o  <= '0;
            viol_cnt_o <= '0;
            pass_o     <= 1'b0;
        end else begin
            if (sample_valid_i) begin
                if (err > max_err_o) begin
                    max_err_o <= err;
                end
                sum_err_o  <= sum_err_o + SUM_W'(err);
                viol_cnt_o <= viol_next;
            end
            if (finalize_i) begin
                pass_o <= (viol_next == '0);
            end
        end
    end

endmodule

// File: rtl/approx_error_monitor.sv
// Exhaustive sweep harness for an approximate multiplier: drives every input vector,
// realigns the circuit response by RESP_LAT cycles and reports error metrics.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i; results of the last sweep held
// SWEEP | stim_o walks 0 .. 2^IN_W-1, one vector per cycle
// DRAIN | RESP_LAT cycles for the last responses to arrive
// DONE  | one-cycle done_o, results final
module approx_error_monitor
    import mul_eval_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int ET       = DEF_ET,
    parameter int RESP_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic [IN_W-1:0]       stim_o,
    output logic                  stim_valid_o,
    input  logic [OUT_W-1:0]      resp_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [OUT_W-1:0]      max_err_o,
    output logic [OUT_W+IN_W-1:0] sum_err_o,
    output logic [IN_W:0]         viol_cnt_o,
    output logic                  pass_o
);

    localparam int              HALF       = IN_W / 2;
    localparam logic [IN_W-1:0] LAST_VEC   = '1;
    localparam logic [1:0]      DRAIN_LOAD = (RESP_LAT > 0) ? 2'(RESP_LAT - 1) : 2'd0;

    if (OUT_W != IN_W) begin : g_bad_width
        $error("approx_error_monitor: OUT_W must equal IN_W");
    end
    if (RESP_LAT < 0 || RESP_LAT > 3) begin : g_bad_lat
        $error("approx_error_monitor: RESP_LAT must be in 0..3");
    end

    state_t          state;
    logic [1:0]      drain_cnt;
    logic            start_ok;
    logic            enter_done;
    logic            sample_valid;
    logic [IN_W-1:0] sample_stim;
    logic [OUT_W-1:0] exact;

    // Sweep start and the edge on which results become final.
    always_comb begin
        start_ok   = (state == IDLE) && start_i;
        enter_done = ((state == SWEEP) && (stim_o == LAST_VEC) && (RESP_LAT == 0)) ||
                     ((state == DRAIN) && (drain_cnt == 2'd0));
    end

    // Sequencer FSM with registered stimulus and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            stim_o       <= '0;
            stim_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            drain_cnt    <= 2'd0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state        <= SWEEP;
                        stim_o       <= '0;
                        stim_valid_o <= 1'b1;
                        busy_o       <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (stim_o == LAST_VEC) begin
                        stim_valid_o <= 1'b0;
                        if (enter_done) begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end else begin
                        stim_o <= stim_o + IN_W'(1);
                    end
                end
                DRAIN: begin
                    if (enter_done) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The operands travel with their valid flag so the exact product lines up with resp_i.
    if (RESP_LAT == 0) begin : g_no_pipe
        assign sample_valid = stim_valid_o;
        assign sample_stim  = stim_o;
    end else begin : g_pipe
        logic [IN_W:0] pipe [RESP_LAT];

        // Latency-matching shift register for {valid, b, a}.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < RESP_LAT; i++) begin
                    pipe[i] <= '0;
                end
            end else begin
                pipe[0] <= {stim_valid_o, stim_o};
                for (int i = 1; i < RESP_LAT; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign sample_valid = pipe[RESP_LAT-1][IN_W];
        assign sample_stim  = pipe[RESP_LAT-1][IN_W-1:0];
    end

    assign exact = OUT_W'(exact_mul(OP_W'(sample_stim[HALF-1:0]), OP_W'(sample_stim[IN_W-1:HALF])));

    err_accum #(
        .W     (OUT_W),
        .SUM_W (OUT_W + IN_W),
        .CNT_W (IN_W + 1),
        .ET    (ET)
    ) u_err_accum (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (start_ok),
        .sample_valid_i (sample_valid),
        .finalize_i     (enter_done),
        .exact_i        (exact),
        .approx_i       (resp_i),
        .max_err_o      (max_err_o),
        .sum_err_o      (sum_err_o),
        .viol_cnt_o     (viol_cnt_o),
        .pass_o         (pass_o)
    );

endmodule

// File: tb/tb_approx_error_monitor.sv
// Bench for approx_error_monitor: three instances (defaults, ET=3, RESP_LAT=2) fed by
// lookup-table circuit models and checked against an arithmetic reference.
module tb_approx_error_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] start_v = 3'b000;

    logic [3:0] stim0, stim1, stim2;
    logic       val0, val1, val2;
    logic [3:0] resp0, resp1, resp2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic [3:0] max0, max1, max2;
    logic [7:0] sum0, sum1, sum2;
    logic [4:0] viol0, viol1, viol2;
    logic       pass0, pass1, pass2;

    logic [3:0] lut0 [16];
    logic [3:0] lut1 [16];
    logic [3:0] lut2 [16];
    logic [3:0] dly  [3];
    int         depth2 = 2;

    assign resp0 = lut0[stim0];
    assign resp1 = lut1[stim1];
    assign resp2 = (depth2 == 3) ? dly[2] : dly[1];

    always_ff @(posedge clk) begin
        dly[0] <= lut2[stim2];
        dly[1] <= dly[0];
        dly[2] <= dly[1];
    end

    approx_error_monitor u_dut0 (
        .clk(clk), .rst(rst), .start_i(start_v[0]), .stim_o(stim0), .stim_valid_o(val0),
        .resp_i(resp0), .busy_o(busy0), .done_o(done0), .max_err_o(max0), .sum_err_o(sum0),
        .viol_cnt_o(viol0), .pass_o(pass0));

    approx_error_monitor #(.ET(3)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start_v[1]), .stim_o(stim1), .stim_valid_o(val1),
        .resp_i(resp1), .busy_o(busy1), .done_o(done1), .max_err_o(max1), .sum_err_o(sum1),
        .viol_cnt_o(viol1), .pass_o(pass1));

    approx_error_monitor #(.RESP_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start_i(start_v[2]), .stim_o(stim2), .stim_valid_o(val2),
        .resp_i(resp2), .busy_o(busy2), .done_o(done2), .max_err_o(max2), .sum_err_o(sum2),
        .viol_cnt_o(viol2), .pass_o(pass2));

    int         sel = 0;
    logic [3:0] s_stim, s_max;
    logic [7:0] s_sum;
    logic [4:0] s_viol;
    logic       s_val, s_busy, s_done, s_pass;

    always_comb begin
        s_stim = stim0; s_val = val0; s_busy = busy0; s_done = done0;
        s_max = max0; s_sum = sum0; s_viol = viol0; s_pass = pass0;
        if (sel == 1) begin
            s_stim = stim1; s_val = val1; s_busy = busy1; s_done = done1;
            s_max = max1; s_sum = sum1; s_viol = viol1; s_pass = pass1;
        end else if (sel == 2) begin
            s_stim = stim2; s_val = val2; s_busy = busy2; s_done = done2;
            s_max = max2; s_sum = sum2; s_viol = viol2; s_pass = pass2;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: exhaustive error metrics of a response table, straight from the definition.
    function automatic void model(input logic [3:0] t [16], input int et,
                                  output int mx, output int sm, output int vc);
        mx = 0; sm = 0; vc = 0;
        for (int v = 0; v < 16; v++) begin
            int ex, e;
            ex = (v % 4) * (v / 4);
            e  = ex - int'(t[v]);
            if (e < 0) e = -e;
            if (e > mx) mx = e;
            sm += e;
            if (e > et) vc++;
        end
    endfunction

    // exp_sum < 0 means only "sum must be nonzero" is required.
    task automatic run_sweep(input int dut, input int exp_done, input int exp_max, input int exp_sum,
                             input int exp_viol, input bit exp_pass, input string nm);
        int done_cycle;
        bit seq_ok;
        done_cycle = -1;
        seq_ok     = 1'b1;
        sel        = dut;
        @(negedge clk); start_v[dut] = 1'b1;
        @(negedge clk); start_v[dut] = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (s_done) begin
                done_cycle = c;
                break;
            end
            if (!s_busy) seq_ok = 1'b0;
            if (c <= 16 && (!s_val || s_stim != 4'(c - 1))) seq_ok = 1'b0;
            if (c > 16 && s_val) seq_ok = 1'b0;
            @(negedge clk);
        end
        chk({nm, " done_cycle"}, done_cycle, exp_done);
        chk({nm, " stim_busy_seq"}, int'(seq_ok), 1);
        if (exp_sum < 0) begin
            chk({nm, " sum_nonzero"}, int'(s_sum != 8'd0), 1);
        end else begin
            chk({nm, " max_err"}, int'(s_max), exp_max);
            chk({nm, " sum_err"}, int'(s_sum), exp_sum);
            chk({nm, " viol_cnt"}, int'(s_viol), exp_viol);
            chk({nm, " pass"}, int'(s_pass), int'(exp_pass));
        end
        @(negedge clk);
        chk({nm, " after_done_idle"}, int'({s_done, s_busy, s_val}), 0);
        if (exp_sum >= 0) begin
            chk({nm, " held_pass_sum"}, int'({s_pass, s_sum}), int'({exp_pass, 8'(exp_sum)}));
        end
    endtask

    typedef struct {
        int         kind;   // 0 ideal product, 1 constant, 2 random table
        logic [3:0] cval;
        int         dut;
        int         depth;
        int         exp_done;
        int         exp_max;
        int         exp_sum;
        int         exp_viol;
        bit         exp_pass;
    } vec_t;

    vec_t       vecs [13];
    logic [3:0] tmp  [16];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 4'd0,  0, 2, 17, 0,  0,   0,  1'b1};
        vecs[1]  = '{1, 4'd5,  0, 2, 17, 5,  56,  0,  1'b1};
        vecs[2]  = '{1, 4'd0,  0, 2, 17, 9,  36,  3,  1'b0};
        vecs[3]  = '{1, 4'd15, 0, 2, 17, 15, 204, 16, 1'b0};
        vecs[4]  = '{2, 4'd0,  0, 2, 17, 0,  0,   0,  1'b0};
        vecs[5]  = '{2, 4'd0,  0, 2, 17, 0,  0,   0,  1'b0};
        vecs[6]  = '{1, 4'd5,  1, 2, 17, 5,  56,  9,  1'b0};
        vecs[7]  = '{0, 4'd0,  1, 2, 17, 0,  0,   0,  1'b1};
        vecs[8]  = '{2, 4'd0,  1, 2, 17, 0,  0,   0,  1'b0};
        vecs[9]  = '{0, 4'd0,  2, 2, 19, 0,  0,   0,  1'b1};
        vecs[10] = '{2, 4'd0,  2, 2, 19, 0,  0,   0,  1'b0};
        vecs[11] = '{1, 4'd5,  2, 2, 19, 5,  56,  0,  1'b1};
        vecs[12] = '{0, 4'd0,  2, 3, 19, 0,  -1,  0,  1'b0};

        for (int v = 0; v < 16; v++) begin
            lut0[v] = 4'd0; lut1[v] = 4'd0; lut2[v] = 4'd0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        sel = 0;
        chk("reset outputs", int'({s_stim, s_val, s_busy, s_done, s_max, s_sum, s_viol, s_pass}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven sweeps
        for (int k = 0; k < 13; k++) begin
            int mx, sm, vc;
            for (int v = 0; v < 16; v++) begin
                case (vecs[k].kind)
                    0:       tmp[v] = 4'((v % 4) * (v / 4));
                    1:       tmp[v] = vecs[k].cval;
                    default: tmp[v] = 4'($urandom_range(0, 15));
                endcase
            end
            if (vecs[k].kind == 2) begin
                model(tmp, (vecs[k].dut == 1) ? 3 : 5, mx, sm, vc);
                vecs[k].exp_max  = mx;
                vecs[k].exp_sum  = sm;
                vecs[k].exp_viol = vc;
                vecs[k].exp_pass = (vc == 0);
            end
            case (vecs[k].dut)
                0:       lut0 = tmp;
                1:       lut1 = tmp;
                default: lut2 = tmp;
            endcase
            depth2 = vecs[k].depth;
            run_sweep(vecs[k].dut, vecs[k].exp_done, vecs[k].exp_max, vecs[k].exp_sum,
                      vecs[k].exp_viol, vecs[k].exp_pass, $sformatf("vec%0d", k));
            repeat (2) @(negedge clk);
        end

        // Extra start pulses: cycle 5 and the done cycle ignored, cycle 18 accepted
        begin
            int first_done, second_done, sum_at_second;
            first_done = -1; second_done = -1; sum_at_second = -1;
            for (int v = 0; v < 16; v++) lut0[v] = 4'd5;
            sel = 0;
            @(negedge clk); start_v[0] = 1'b1;
            @(negedge clk); start_v[0] = 1'b0;
            for (int c = 1; c <= 45; c++) begin
                if (done0) begin
                    if (first_done < 0) first_done = c;
                    else if (second_done < 0) begin
                        second_done   = c;
                        sum_at_second = int'(sum0);
                    end
                end
                if (c == 17) chk("restart held_max_before", int'(max0), 5);
                if (c == 18) chk("restart ignored_in_done busy", int'({busy0, val0}), 0);
                if (c == 19) begin
                    chk("restart accepted busy_valid_stim", int'({busy0, val0, stim0}), int'({2'b11, 4'd0}));
                    chk("restart cleared sum_max_pass", int'({sum0, max0, pass0}), 0);
                end
                start_v[0] = (c == 5 || c == 17 || c == 18);
                @(negedge clk);
            end
            start_v[0] = 1'b0;
            chk("restart first_done", first_done, 17);
            chk("restart second_done", second_done, 35);
            chk("restart second_sum", sum_at_second, 56);
        end
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-sweep, then a clean sweep
        begin
            bit saw_done;
            int mx, sm, vc;
            saw_done = 1'b0;
            for (int v = 0; v < 16; v++) lut0[v] = 4'd5;
            sel = 0;
            @(negedge clk); start_v[0] = 1'b1;
            @(negedge clk); start_v[0] = 1'b0;
            repeat (7) @(negedge clk);
            chk("midrst sum_before", int'(sum0), 32);
            rst = 1'b1;
            #1;
            chk("midrst outputs_zero",
                int'({stim0, val0, busy0, done0, max0, sum0, viol0, pass0}), 0);
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 25; c++) begin
                if (done0 || busy0) saw_done = 1'b1;
                @(negedge clk);
            end
            chk("midrst no_done_after", int'(saw_done), 0);
            for (int v = 0; v < 16; v++) tmp[v] = 4'($urandom_range(0, 15));
            lut0 = tmp;
            model(tmp, 5, mx, sm, vc);
            run_sweep(0, 17, mx, sm, vc, (vc == 0), "post_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
